// File: rtl/controle_hazard_pipeline.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline:
// load-use bubbles, redirect flushes, memory-wait freeze with timeout,
// and saturating stall/flush performance counters.
module controle_hazard_pipeline #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_MemRead,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             global_stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [4:0]        ex_rd_q;
  logic              ex_MemRead_q;
  logic              mem_wait_c;
  logic              load_use_c;

  // Hazard detection against the ID/EX shadow copy; x0 never stalls
  always_comb begin
    load_use_c = 1'b0;
    if (ex_MemRead_q && (ex_rd_q != 5'd0)) begin
      load_use_c = (id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd_q));
    end
    mem_wait_c = ((state_q == RUN) && mem_req && !mem_ready) ||
                 ((state_q == MEM_WAIT) && !mem_ready);
  end

  // Next-state and prioritised pipeline control outputs
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    global_stall = 1'b0;
    mem_timeout  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = WAIT_W'(wait_cnt_q + WAIT_W'(1));
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (state_q == ERROR) begin
      global_stall = 1'b1;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      mem_timeout  = 1'b1;
    end else if (mem_wait_c) begin
      global_stall = 1'b1;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (load_use_c) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ID/EX shadow of rd/MemRead; a bubble clears it, a freeze holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q      <= '0;
      ex_MemRead_q <= 1'b0;
    end else if (!global_stall) begin
      if (idex_flush) begin
        ex_rd_q      <= '0;
        ex_MemRead_q <= 1'b0;
      end else begin
        ex_rd_q      <= id_rd;
        ex_MemRead_q <= id_MemRead;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != '1)) begin
        stall_count <= CNT_W'(stall_count + CNT_W'(1));
      end
      if (ex_redirect && !global_stall && (flush_count != '1)) begin
        flush_count <= CNT_W'(flush_count + CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_controle_hazard_pipeline.sv
// Directed self-checking bench for controle_hazard_pipeline (MAX_WAIT=4, CNT_W=4).
module tb_controle_hazard_pipeline;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_uses_rs1, id_uses_rs2, id_MemRead;
  logic             ex_redirect, mem_req, mem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_flush;
  logic             global_stall, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  controle_hazard_pipeline #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_MemRead(id_MemRead),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .global_stall(global_stall), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_MemRead = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Control outputs as a packed tuple {pc_write, ifid_write, ifid_flush, idex_flush, global_stall, mem_timeout}
  function automatic logic [31:0] ctl();
    return 32'({pc_write, ifid_write, ifid_flush, idex_flush, global_stall, mem_timeout});
  endfunction

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #3;
    check_val("reset_ctl", ctl(), 32'b110000);
    check_val("reset_stall_cnt", 32'(stall_count), 32'd0);
    check_val("reset_flush_cnt", 32'(flush_count), 32'd0);
    #9;
    rst_n = 1'b1;
    tick();
    tick();
    check_val("idle_ctl", ctl(), 32'b110000);
    check_val("idle_cnt", 32'({stall_count, flush_count}), 32'h00);

    // Load-use on rs1 with rd=5
    id_rd = 5'd5; id_MemRead = 1'b1;
    @(negedge clk);
    check_val("lu_pre_ctl", ctl(), 32'b110000);
    tick();
    id_rd = '0; id_MemRead = 1'b0; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    @(negedge clk);
    check_val("lu_stall_ctl", ctl(), 32'b000100);
    tick();
    check_val("lu_stall_cnt", 32'(stall_count), 32'd1);
    @(negedge clk);
    check_val("lu_release_ctl", ctl(), 32'b110000);
    tick();
    check_val("lu_one_cycle_cnt", 32'(stall_count), 32'd1);

    // Load into x0 followed by a reader of x0: no stall
    id_rd = 5'd0; id_MemRead = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    tick();
    id_MemRead = 1'b0;
    @(negedge clk);
    check_val("x0_no_stall_ctl", ctl(), 32'b110000);
    tick();
    check_val("x0_stall_cnt", 32'(stall_count), 32'd1);

    // Load-use on rs2 path
    id_rs1 = '0; id_uses_rs1 = 1'b0; id_rd = 5'd9; id_MemRead = 1'b1;
    tick();
    id_rd = '0; id_MemRead = 1'b0; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    @(negedge clk);
    check_val("lu_rs2_ctl", ctl(), 32'b000100);
    tick();
    check_val("lu_rs2_cnt", 32'(stall_count), 32'd2);

    // Redirect coincident with a load-use hazard: redirect wins
    do_reset();
    id_rd = 5'd5; id_MemRead = 1'b1;
    tick();
    id_rd = '0; id_MemRead = 1'b0; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_redirect = 1'b1;
    @(negedge clk);
    check_val("redir_lu_ctl", ctl(), 32'b111100);
    tick();
    check_val("redir_flush_cnt", 32'(flush_count), 32'd1);
    check_val("redir_stall_cnt", 32'(stall_count), 32'd0);
    ex_redirect = 1'b0;
    @(negedge clk);
    check_val("redir_bubble_clears_ctl", ctl(), 32'b110000);

    // Memory wait of 3 cycles with a redirect held through the freeze
    do_reset();
    mem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("memwait_ctl_%0d", i), ctl(), 32'b000010);
      tick();
    end
    check_val("memwait_flush_held", 32'(flush_count), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    check_val("memwait_release_ctl", ctl(), 32'b111100);
    tick();
    check_val("memwait_stall_cnt", 32'(stall_count), 32'd3);
    check_val("memwait_flush_cnt", 32'(flush_count), 32'd1);
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    check_val("memwait_flush_once", 32'(flush_count), 32'd1);

    // Zero-wait access does not stall
    mem_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check_val("zero_wait_ctl", ctl(), 32'b110000);
    tick();
    check_val("zero_wait_cnt", 32'(stall_count), 32'd3);

    // Timeout: RUN cycle plus MAX_WAIT cycles in MEM_WAIT, then ERROR
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("to_wait_ctl_%0d", i), ctl(), 32'b000010);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check_val("to_error_ctl", ctl(), 32'b000011);
    tick();
    check_val("to_stall_cnt", 32'(stall_count), 32'd6);
    @(negedge clk);
    check_val("to_error_sticky", ctl(), 32'b000011);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_ctl", ctl(), 32'b110000);
    check_val("async_rst_cnt", 32'(stall_count), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check_val("after_rst_run_ctl", ctl(), 32'b110000);

    // Saturation of the 4-bit stall counter via ERROR
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check_val("sat_pre_cnt", 32'(stall_count), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check_val("sat_hold_cnt", 32'(stall_count), 32'd15);

    do_reset();
    check_val("final_cnt", 32'({stall_count, flush_count}), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
